// File: rtl/iob_fifo_sync_asym_wide_wr_if.sv
// ---------------------------------------------------------------------------
// iob_fifo_sync_asym_wide_wr_if
// User-side bundle of the wide-write / narrow-read synchronous FIFO.
//
// Handshake: w_en_i is a write request and is taken in a cycle only when
// full_o is low in that cycle; r_en_i is a read request and is taken only
// when empty_o is low. A taken read returns its word on r_data_o with
// r_valid_o high exactly one cycle later. Requests made against full_o or
// empty_o are dropped without side effects.
//
// Signals:
//   w_en_i, w_data_i         write request and wide write word
//   full_o                   no room for another wide word
//   r_en_i                   read request
//   r_data_o, r_valid_o      narrow read word and its valid strobe
//   empty_o, level_o         occupancy flags / count in narrow words
//   err_clr_i, overflow_o,   sticky error flags, present only when
//   underflow_o              IOB_FIFO_ASYM_ERR_EN is defined
// Modports: master = producer/consumer side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface iob_fifo_sync_asym_wide_wr_if #(
   parameter int W_DATA_W = 32,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
);
   logic                w_en_i;
   logic [W_DATA_W-1:0] w_data_i;
   logic                full_o;
   logic                r_en_i;
   logic [R_DATA_W-1:0] r_data_o;
   logic                r_valid_o;
   logic                empty_o;
   logic [ADDR_W:0]     level_o;
`ifdef IOB_FIFO_ASYM_ERR_EN
   logic                err_clr_i;
   logic                overflow_o;
   logic                underflow_o;

   modport master (
      output w_en_i, w_data_i, r_en_i, err_clr_i,
      input  full_o, r_data_o, r_valid_o, empty_o, level_o, overflow_o, underflow_o
   );
   modport slave (
      input  w_en_i, w_data_i, r_en_i, err_clr_i,
      output full_o, r_data_o, r_valid_o, empty_o, level_o, overflow_o, underflow_o
   );
`else
   modport master (
      output w_en_i, w_data_i, r_en_i,
      input  full_o, r_data_o, r_valid_o, empty_o, level_o
   );
   modport slave (
      input  w_en_i, w_data_i, r_en_i,
      output full_o, r_data_o, r_valid_o, empty_o, level_o
   );
`endif
endinterface

// File: rtl/iob_fifo_sync_asym_wide_wr.sv
// ---------------------------------------------------------------------------
// iob_fifo_sync_asym_wide_wr
// Single-clock FIFO with a wide write port and a narrow read port, backed by
// R external symmetric banks (R_DATA_W x 2^MINADDR_W, registered read).
// A wide word is written to all banks at once at row w_ptr; narrow words are
// read one bank at a time, slice 0 first.
//
// Ports:
//   clk_i, arst_n_i        clock, asynchronous active-low reset
//   fifo_if (slave)        user write/read handshake, flags and level
//   ext_mem_w_en_o         per-bank write enables
//   ext_mem_w_addr_o       per-bank write addresses (all equal)
//   ext_mem_w_data_o       per-bank write data (bank p = slice p)
//   ext_mem_r_en_o         read enable shared by all banks
//   ext_mem_r_addr_o       per-bank read addresses (all equal)
//   ext_mem_r_data_i       per-bank read data, one cycle after r_en
//
// Optional feature: define IOB_FIFO_ASYM_ERR_EN to add sticky overflow_o /
// underflow_o flags and their err_clr_i clear input on the interface.
// ---------------------------------------------------------------------------
module iob_fifo_sync_asym_wide_wr #(
   parameter  int W_DATA_W  = 32,
   parameter  int R_DATA_W  = 8,
   parameter  int ADDR_W    = 4,
   localparam int R         = W_DATA_W / R_DATA_W,
   localparam int R_LOG     = $clog2(R),
   localparam int MINADDR_W = ADDR_W - R_LOG
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   iob_fifo_sync_asym_wide_wr_if.slave fifo_if,
   output logic [R-1:0]              ext_mem_w_en_o,
   output logic [MINADDR_W*R-1:0]    ext_mem_w_addr_o,
   output logic [R_DATA_W*R-1:0]     ext_mem_w_data_o,
   output logic                      ext_mem_r_en_o,
   output logic [MINADDR_W*R-1:0]    ext_mem_r_addr_o,
   input  logic [R_DATA_W*R-1:0]     ext_mem_r_data_i
);
   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] R_INC    = (ADDR_W + 1)'(R);
   localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'(DEPTH - R);

   logic [MINADDR_W-1:0] w_ptr;
   logic [ADDR_W-1:0]    r_ptr;
   logic [ADDR_W:0]      level;
   logic [ADDR_W:0]      level_nxt;
   logic                 empty_q;
   logic                 full_q;
   logic                 r_valid_q;
   logic [R_DATA_W-1:0]  r_mux;
   logic [R_DATA_W-1:0]  r_hold;
   logic                 w_acc;
   logic                 r_acc;

   // Gating with arst_n_i keeps the bank strobes quiet for the whole reset,
   // not just after the registers have settled.
   assign w_acc = fifo_if.w_en_i & ~full_q & arst_n_i;
   assign r_acc = fifo_if.r_en_i & ~empty_q & arst_n_i;

   // The full threshold leaves at least one free row, so the write row can
   // never coincide with the row still being read.
   assign ext_mem_w_en_o   = {R{w_acc}};
   assign ext_mem_w_addr_o = {R{w_ptr}};
   assign ext_mem_w_data_o = fifo_if.w_data_i;
   assign ext_mem_r_en_o   = r_acc;
   assign ext_mem_r_addr_o = {R{r_ptr[ADDR_W-1:R_LOG]}};

   always_comb begin
      level_nxt = level;
      if (w_acc) level_nxt = level_nxt + R_INC;
      if (r_acc) level_nxt = level_nxt - (ADDR_W + 1)'(1);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         level     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         r_valid_q <= 1'b0;
         r_hold    <= '0;
      end else begin
         if (w_acc) w_ptr <= w_ptr + MINADDR_W'(1);
         if (r_acc) r_ptr <= r_ptr + ADDR_W'(1);
         level     <= level_nxt;
         // Flags come from the next level so they line up with level_o.
         empty_q   <= (level_nxt == '0);
         full_q    <= (level_nxt > FULL_THR);
         r_valid_q <= r_acc;
         if (r_valid_q) r_hold <= r_mux;
      end
   end

   generate
      if (R_LOG > 0) begin : g_banked
         logic [R_LOG-1:0] sel_q;

         always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i)  sel_q <= '0;
            else if (r_acc) sel_q <= r_ptr[R_LOG-1:0];
         end

         assign r_mux = ext_mem_r_data_i[int'(sel_q)*R_DATA_W +: R_DATA_W];
      end else begin : g_single
         assign r_mux = ext_mem_r_data_i;
      end
   endgenerate

   // Bank outputs may move on later writes, so the last word is held locally.
   assign fifo_if.r_data_o  = r_valid_q ? r_mux : r_hold;
   assign fifo_if.r_valid_o = r_valid_q;
   assign fifo_if.empty_o   = empty_q;
   assign fifo_if.full_o    = full_q;
   assign fifo_if.level_o   = level;

`ifdef IOB_FIFO_ASYM_ERR_EN
   logic overflow_q;
   logic underflow_q;
   logic ov_set;
   logic uf_set;

   assign ov_set = fifo_if.w_en_i & full_q;
   assign uf_set = fifo_if.r_en_i & empty_q;

   // A new error event in the clear cycle takes priority over the clear.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (ov_set)                 overflow_q  <= 1'b1;
         else if (fifo_if.err_clr_i) overflow_q  <= 1'b0;
         if (uf_set)                 underflow_q <= 1'b1;
         else if (fifo_if.err_clr_i) underflow_q <= 1'b0;
      end
   end

   assign fifo_if.overflow_o  = overflow_q;
   assign fifo_if.underflow_o = underflow_q;
`endif
endmodule

// File: tb/tb_iob_fifo_sync_asym_wide_wr.sv
// ---------------------------------------------------------------------------
// tb_iob_fifo_sync_asym_wide_wr
// Bench for the wide-write / narrow-read FIFO: external bank model, a byte
// queue reference model, a vector table for the basic flow and hand-written
// sequences for full, simultaneous access, wrap-around and reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_fifo_sync_asym_wide_wr;
   localparam int W_DATA_W   = 32;
   localparam int R_DATA_W   = 8;
   localparam int ADDR_W     = 4;
   localparam int R          = W_DATA_W / R_DATA_W;
   localparam int R_LOG      = $clog2(R);
   localparam int MINADDR_W  = ADDR_W - R_LOG;
   localparam int DEPTH      = 2 ** ADDR_W;
   localparam int BANK_DEPTH = 2 ** MINADDR_W;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic arst_n = 1'b1;
   always #5 clk = ~clk;

   logic [R-1:0]             ext_mem_w_en;
   logic [MINADDR_W*R-1:0]   ext_mem_w_addr;
   logic [R_DATA_W*R-1:0]    ext_mem_w_data;
   logic                     ext_mem_r_en;
   logic [MINADDR_W*R-1:0]   ext_mem_r_addr;
   logic [R_DATA_W*R-1:0]    ext_mem_r_data;

   iob_fifo_sync_asym_wide_wr_if #(
      .W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .ADDR_W(ADDR_W)
   ) fifo_if ();

   iob_fifo_sync_asym_wide_wr #(
      .W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk_i            (clk),
      .arst_n_i         (arst_n),
      .fifo_if          (fifo_if.slave),
      .ext_mem_w_en_o   (ext_mem_w_en),
      .ext_mem_w_addr_o (ext_mem_w_addr),
      .ext_mem_w_data_o (ext_mem_w_data),
      .ext_mem_r_en_o   (ext_mem_r_en),
      .ext_mem_r_addr_o (ext_mem_r_addr),
      .ext_mem_r_data_i (ext_mem_r_data)
   );

   // ---------------- external banks ----------------
   logic [R_DATA_W-1:0] mem [R][BANK_DEPTH];
   always @(posedge clk) begin
      for (int p = 0; p < R; p++) begin
         if (ext_mem_w_en[p])
            mem[p][ext_mem_w_addr[p*MINADDR_W +: MINADDR_W]] <= ext_mem_w_data[p*R_DATA_W +: R_DATA_W];
         if (ext_mem_r_en)
            ext_mem_r_data[p*R_DATA_W +: R_DATA_W] <= mem[p][ext_mem_r_addr[p*MINADDR_W +: MINADDR_W]];
      end
   end

   // ---------------- scoreboard ----------------
   logic [R_DATA_W-1:0] model_q[$];  // bytes stored, oldest first
   logic [R_DATA_W-1:0] exp_q[$];    // bytes read, due on r_data_o next cycle
   logic ov_m = 1'b0;
   logic uf_m = 1'b0;
   logic [R-1:0] last_w_en;
   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic check_state();
      chk("level", 64'(fifo_if.level_o), 64'(model_q.size()));
      chk("empty", 64'(fifo_if.empty_o), 64'(model_q.size() == 0));
      chk("full",  64'(fifo_if.full_o),  64'(model_q.size() > DEPTH - R));
      if (exp_q.size() > 0) begin
         chk("r_valid", 64'(fifo_if.r_valid_o), 64'd1);
         chk("r_data",  64'(fifo_if.r_data_o),  64'(exp_q.pop_front()));
      end else begin
         chk("r_valid", 64'(fifo_if.r_valid_o), 64'd0);
      end
`ifdef IOB_FIFO_ASYM_ERR_EN
      chk("overflow",  64'(fifo_if.overflow_o),  64'(ov_m));
      chk("underflow", 64'(fifo_if.underflow_o), 64'(uf_m));
`endif
   endtask

   // One clock cycle: drive, check mid-cycle against the model, advance.
   task automatic cycle(input logic we, input logic [W_DATA_W-1:0] wd, input logic re, input logic clr);
      logic acc_w;
      logic acc_r;
      fifo_if.w_en_i   = we;
      fifo_if.w_data_i = wd;
      fifo_if.r_en_i   = re;
`ifdef IOB_FIFO_ASYM_ERR_EN
      fifo_if.err_clr_i = clr;
`endif
      @(negedge clk);
      check_state();
      acc_w = we && (model_q.size() + R <= DEPTH);
      acc_r = re && (model_q.size() > 0);
      last_w_en = ext_mem_w_en;
      chk("mem_w_en", 64'(ext_mem_w_en), acc_w ? 64'({R{1'b1}}) : 64'd0);
      chk("mem_r_en", 64'(ext_mem_r_en), 64'(acc_r));
      if (acc_r) exp_q.push_back(model_q.pop_front());
      if (acc_w)
         for (int p = 0; p < R; p++) model_q.push_back(wd[p*R_DATA_W +: R_DATA_W]);
      if (we && !acc_w) ov_m = 1'b1;
      else if (clr)     ov_m = 1'b0;
      if (re && !acc_r) uf_m = 1'b1;
      else if (clr)     uf_m = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      // Requests held high through reset must not reach the banks.
      fifo_if.w_en_i   = 1'b1;
      fifo_if.w_data_i = 32'hCAFEF00D;
      fifo_if.r_en_i   = 1'b1;
`ifdef IOB_FIFO_ASYM_ERR_EN
      fifo_if.err_clr_i = 1'b0;
`endif
      arst_n = 1'b0;
      #1;
      model_q.delete();
      exp_q.delete();
      ov_m = 1'b0;
      uf_m = 1'b0;
      chk("rst level",   64'(fifo_if.level_o),   64'd0);
      chk("rst empty",   64'(fifo_if.empty_o),   64'd1);
      chk("rst full",    64'(fifo_if.full_o),    64'd0);
      chk("rst r_valid", 64'(fifo_if.r_valid_o), 64'd0);
      @(negedge clk);
      chk("rst mem_w_en", 64'(ext_mem_w_en), 64'd0);
      chk("rst mem_r_en", 64'(ext_mem_r_en), 64'd0);
      fifo_if.w_en_i = 1'b0;
      fifo_if.r_en_i = 1'b0;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic                we;
      logic [W_DATA_W-1:0] wd;
      logic                re;
      logic [ADDR_W:0]     exp_level;
      logic                exp_empty;
      logic                exp_full;
      logic                exp_rvalid;
      logic [R_DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic we;
      logic re;
      logic clr;
      int   phase;

      vecs[0] = '{1'b1, 32'h44332211, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 32'h0,        1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 8'h11};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 8'h22};
      vecs[3] = '{1'b0, 32'h0,        1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'h33};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h44};
      vecs[5] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{1'b1, 32'h04030201, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[8] = '{1'b0, 32'h0,        1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 8'h01};
      vecs[9] = '{1'b0, 32'h0,        1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'h00};

      fifo_if.w_en_i   = 1'b0;
      fifo_if.w_data_i = '0;
      fifo_if.r_en_i   = 1'b0;
`ifdef IOB_FIFO_ASYM_ERR_EN
      fifo_if.err_clr_i = 1'b0;
`endif
      #1;

      // ---- basic order, empty read, write with read on empty ----
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].we, vecs[i].wd, vecs[i].re, 1'b0);
         chk($sformatf("vec%0d level", i),   64'(fifo_if.level_o),   64'(vecs[i].exp_level));
         chk($sformatf("vec%0d empty", i),   64'(fifo_if.empty_o),   64'(vecs[i].exp_empty));
         chk($sformatf("vec%0d full", i),    64'(fifo_if.full_o),    64'(vecs[i].exp_full));
         chk($sformatf("vec%0d r_valid", i), 64'(fifo_if.r_valid_o), 64'(vecs[i].exp_rvalid));
         if (vecs[i].exp_rvalid)
            chk($sformatf("vec%0d r_data", i), 64'(fifo_if.r_data_o), 64'(vecs[i].exp_rdata));
`ifdef IOB_FIFO_ASYM_ERR_EN
         if (i == 5) chk("empty read underflow", 64'(fifo_if.underflow_o), 64'd1);
`endif
      end

      // ---- full and overflow ----
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0);
      chk("full after 4", 64'(fifo_if.full_o),  64'd1);
      chk("level 16",     64'(fifo_if.level_o), 64'd16);
      cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("dropped write w_en", 64'(last_w_en),       64'd0);
      chk("level after drop",   64'(fifo_if.level_o), 64'd16);
`ifdef IOB_FIFO_ASYM_ERR_EN
      chk("overflow set", 64'(fifo_if.overflow_o), 64'd1);
`endif
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("level 15",     64'(fifo_if.level_o), 64'd15);
      chk("full at 15",   64'(fifo_if.full_o),  64'd1);
`ifdef IOB_FIFO_ASYM_ERR_EN
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("overflow clr", 64'(fifo_if.overflow_o), 64'd0);
      cycle(1'b1, 32'h12345678, 1'b0, 1'b1);
      chk("set beats clr", 64'(fifo_if.overflow_o), 64'd1);
`endif
      for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("drained empty", 64'(fifo_if.empty_o), 64'd1);

      // ---- simultaneous write and read at level 5 ----
      do_reset();
      cycle(1'b1, 32'h03020100, 1'b0, 1'b0);
      cycle(1'b1, 32'h07060504, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("level 5", 64'(fifo_if.level_o), 64'd5);
      cycle(1'b1, 32'h0B0A0908, 1'b1, 1'b0);
      chk("simul level",   64'(fifo_if.level_o),   64'd8);
      chk("simul r_valid", 64'(fifo_if.r_valid_o), 64'd1);
      chk("simul r_data",  64'(fifo_if.r_data_o),  64'h03);
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      // ---- wrap-around ----
      do_reset();
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 32'hA3A2A1A0 + 32'(k), 1'b0, 1'b0);
         for (int j = 0; j < 4; j++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap empty", 64'(fifo_if.empty_o), 64'd1);
      chk("wrap level", 64'(fifo_if.level_o), 64'd0);

      // ---- reset mid-operation ----
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("pre-rst level",   64'(fifo_if.level_o),   64'd9);
      chk("pre-rst r_valid", 64'(fifo_if.r_valid_o), 64'd1);
      arst_n = 1'b0;
      #1;
      chk("mid-rst level",   64'(fifo_if.level_o),   64'd0);
      chk("mid-rst empty",   64'(fifo_if.empty_o),   64'd1);
      chk("mid-rst r_valid", 64'(fifo_if.r_valid_o), 64'd0);
      model_q.delete();
      exp_q.delete();
      ov_m = 1'b0;
      uf_m = 1'b0;
      fifo_if.w_en_i   = 1'b1;
      fifo_if.w_data_i = 32'h55AA55AA;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid-rst mem_w_en", 64'(ext_mem_w_en), 64'd0);
         @(posedge clk);
      end
      #1;
      fifo_if.w_en_i = 1'b0;
      arst_n = 1'b1;
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      // ---- randomized traffic against the model ----
      do_reset();
      for (int i = 0; i < 400; i++) begin
         phase = (i / 50) % 2;
         we  = ($urandom_range(0, 99) < (phase ? 60 : 20));
         re  = ($urandom_range(0, 99) < (phase ? 30 : 80));
         clr = ($urandom_range(0, 15) == 0);
         cycle(we, 32'($urandom), re, clr);
      end
      for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("final empty", 64'(fifo_if.empty_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/iob_fifo_sync_asym_wide_wr.md
Name: iob_fifo_sync_asym_wide_wr

Overview:
- Single-clock FIFO: wide write port (W_DATA_W), narrow read port (R_DATA_W). Same bank data path as the narrow-write/wide-read RAM wrapper, in the other direction.
- Storage is external: R symmetric banks of R_DATA_W x 2^(ADDR_W-log2(R)), one-cycle registered read.
- Used where a wide producer (bus, DMA) feeds a byte/halfword-oriented consumer (UART, serializer).

Parameters:
- W_DATA_W, 32: write width. Must be R_DATA_W times a power of two.
- R_DATA_W, 8: read width and bank width.
- ADDR_W, 4: narrow-side address width. Capacity is 2^ADDR_W narrow words. ADDR_W >= log2(R).
- R, W_DATA_W/R_DATA_W: bank count (derived).
- MINADDR_W, ADDR_W-log2(R): bank address width (derived).

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- ext_mem_w_en_o  out  R  per-bank write enable.
- ext_mem_w_addr_o  out  MINADDR_W*R  bank write addresses.
- ext_mem_w_data_o  out  R_DATA_W*R  bank write data.
- ext_mem_r_en_o  out  1  bank read enable.
- ext_mem_r_addr_o  out  MINADDR_W*R  bank read addresses.
- ext_mem_r_data_i  in  R_DATA_W*R  bank read data, valid 1 cycle after r_en.
- w_en_i  in  1  write request.
- w_data_i  in  W_DATA_W  write word.
- full_o  out  1  cannot accept a wide word.
- r_en_i  in  1  read request.
- r_data_o  out  R_DATA_W  read data.
- r_valid_o  out  1  r_data_o valid this cycle.
- empty_o  out  1  no narrow word stored.
- level_o  out  ADDR_W+1  occupancy in narrow words.

Behaviour:
- Reset (async assert, sync release): w_ptr=0, r_ptr=0, level_o=0, empty_o=1, full_o=0, r_valid_o=0, sel_q=0. While arst_n_i=0, ext_mem_w_en_o=0 and ext_mem_r_en_o=0.
- Write accept: w_acc = w_en_i & ~full_o.
  - w_ptr is MINADDR_W bits, counting wide words.
  - On w_acc: all R bank enables high, every bank address = w_ptr, bank p data = w_data_i[p*R_DATA_W +: R_DATA_W]. Slice 0 is read out first (little-endian order).
  - w_ptr increments by 1 on w_acc and wraps modulo 2^MINADDR_W.
- Read accept: r_acc = r_en_i & ~empty_o.
  - r_ptr is ADDR_W bits. Bank select = r_ptr[log2(R)-1:0]; all bank read addresses = r_ptr[ADDR_W-1:log2(R)].
  - ext_mem_r_en_o = r_acc. r_ptr increments and wraps modulo 2^ADDR_W.
  - sel_q <= bank select on r_acc. r_valid_o <= r_acc, so latency is 1 cycle.
  - r_data_o = bank sel_q of ext_mem_r_data_i. Holds its last value while r_valid_o=0 and no new read occurs.
- Level update:
  - +R on w_acc only.
  - -1 on r_acc only.
  - +R-1 when both are accepted in the same cycle.
- Flags, registered and derived from the next level:
  - empty_o = (level==0).
  - full_o = (level > 2^ADDR_W - R).
- A write while full and a read while empty are dropped silently: no pointer, level or memory change.
- Same-cycle write and read never address the same storage. Data written in a cycle is readable at the earliest on the next cycle.
- R=1 degenerates to a symmetric sync FIFO: bank select width is 0 and sel_q is unused.

Optional Feature:
- Macro: IOB_FIFO_ASYM_ERR_EN.
- Enabled: adds outputs overflow_o and underflow_o (1 bit each, reset 0) and input err_clr_i.
  - overflow_o is set sticky on w_en_i & full_o.
  - underflow_o is set sticky on r_en_i & empty_o.
  - Both clear on err_clr_i; a set event in the same cycle wins over the clear.
- Disabled: these ports do not exist and dropped requests are silent.

Test Plan (W_DATA_W=32, R_DATA_W=8, ADDR_W=4):
- Basic order:
  - Stimulus: after reset, write 0x44332211, then read 4 times back-to-back.
  - Response: r_valid_o high for 4 cycles, each starting 1 cycle after its read, with r_data_o = 0x11, 0x22, 0x33, 0x44. Then empty_o=1, level_o=0.
- Full and overflow:
  - Stimulus: write 4 words; then a 5th write of 0xDEADBEEF; then 1 read.
  - Response: full_o=1 and level_o=16 after 4 writes. The 5th write is dropped with no ext_mem_w_en_o pulse; overflow_o=1 if enabled. After 1 read, level_o=15 and full_o stays 1 (15 > 12).
- Simultaneous write and read:
  - Stimulus: level=5, then w_en_i=1 and r_en_i=1 in the same cycle.
  - Response: level_o=8, and the read returns the oldest byte.
- Wrap-around:
  - Stimulus: 10 rounds of writing 0xA3A2A1A0+k and reading 4 bytes.
  - Response: pointers wrap, bytes arrive in order with no loss, and the final state is empty.
- Empty read:
  - Stimulus: r_en_i=1 with the FIFO empty.
  - Response: no ext_mem_r_en_o pulse, r_valid_o=0, level_o stays 0; underflow_o=1 if enabled.
- Reset mid-operation:
  - Stimulus: assert arst_n_i=0 with level=9 while a read is in flight.
  - Response: level_o=0, empty_o=1 and r_valid_o=0 immediately. Writes issued during reset produce no ext_mem_w_en_o.
